// File: rtl/shift_arbiter.sv
// Purpose: round-robin scheduler sharing one external logical-right barrel shifter between two requesters.
// Latency: 2 cycles from request acceptance to out_valid; peak throughput is one request per 3 cycles.
// Backpressure: out_valid/out_data/out_id hold until out_ready; no request is accepted until the result drains.
//
// Ports:
//   clk, rst                        clock and asynchronous active-high reset
//   req{0,1}_valid/_data/_amt       request word and shift amount, held by the requester until ready
//   req{0,1}_ready                  combinational grant, high only in IDLE for the arbitration winner
//   sh_in, sh_s                     registered operands driven to the shared shifter
//   sh_result                       combinational shifter output (sh_in >> sh_s)
//   out_valid/out_data/out_id       registered result and the requester that issued it
//   out_ready                       consumer accepts the result
module shift_arbiter #(
    parameter int N = 4,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_data,
    input  logic [S-1:0] req0_amt,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_data,
    input  logic [S-1:0] req1_amt,
    output logic         req1_ready,
    output logic [N-1:0] sh_in,
    output logic [S-1:0] sh_s,
    input  logic [N-1:0] sh_result,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_id,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   ptr;       // requester holding priority when both are valid
    logic   id_q;      // requester whose operands are in the shifter
    logic   grant_id;
    logic   any_valid;
    logic   idle;

    // With a single valid the winner is simply that requester; ties go to ptr.
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? ptr : req1_valid;
    assign idle      = (state == IDLE);

    // Gated by the requester's own valid so that no ready appears when nobody asks.
    assign req0_ready = idle & req0_valid & (grant_id == 1'b0);
    assign req1_ready = idle & req1_valid & (grant_id == 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            id_q      <= 1'b0;
            sh_in     <= '0;
            sh_s      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        sh_in <= grant_id ? req1_data : req0_data;
                        sh_s  <= grant_id ? req1_amt  : req0_amt;
                        id_q  <= grant_id;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Shifter operands have been stable for a full cycle; capture its output.
                    out_data  <= sh_result;
                    out_id    <= id_q;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // The requester just served drops to lower priority.
                        ptr       <= ~out_id;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Purpose: directed, self-checking bench for shift_arbiter with an expected-result scoreboard.
// Latency: checks 2-cycle acceptance-to-result latency and 3-cycle request spacing.
// Backpressure: holds out_ready low to verify the result stays stable and no grant is issued.
module tb_shift_arbiter;

    localparam int N = 4;
    localparam int S = 2;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic [N-1:0] req0_data;
    logic [S-1:0] req0_amt;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_data;
    logic [S-1:0] req1_amt;
    logic         req1_ready;
    logic [N-1:0] sh_in;
    logic [S-1:0] sh_s;
    logic [N-1:0] sh_result;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_id;
    logic         out_ready;

    shift_arbiter #(.N(N), .S(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_ready (req1_ready),
        .sh_in      (sh_in),
        .sh_s       (sh_s),
        .sh_result  (sh_result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    // The shared shifter that sits beside the arbiter at the top level.
    assign sh_result = sh_in >> sh_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic         id;
        logic [N-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   vecs = 0;
    int   miss = 0;
    int   last_grant_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, check it went to exp_id, optionally push the expected result,
    // then step past the accepting edge.
    task automatic wait_grant(input logic exp_id, input bit push, output int waited);
        exp_t e;
        waited = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (waited < 0 && (req0_ready || req1_ready)) waited = k;
            if (waited >= 0) break;
        end
        if (waited < 0) begin
            chk("grant_timeout", 32'd0, 32'd1);
        end else begin
            chk("grant_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
            chk("grant_id", {31'd0, req1_ready}, {31'd0, exp_id});
            if (push) begin
                e.id   = exp_id;
                e.data = exp_id ? (req1_data >> req1_amt) : (req0_data >> req0_amt);
                sbq.push_back(e);
                last_grant_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for out_valid and compare against the oldest scoreboard entry.
    task automatic wait_result();
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("result_timeout", 32'd0, 32'd1);
        end else if (sbq.size() == 0) begin
            chk("result_unexpected", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("out_data", {28'd0, out_data}, {28'd0, e.data});
            chk("out_id", {31'd0, out_id}, {31'd0, e.id});
            chk("latency", cyc - last_grant_cyc, 32'd2);
        end
    endtask

    // One isolated request from requester id, result drained with out_ready high.
    task automatic serve(input logic id, input logic [N-1:0] d, input logic [S-1:0] a);
        int w;
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a;
        end
        wait_grant(id, 1'b1, w);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_result();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int g1;

        rst = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_amt = '0;
        req1_valid = 1'b0; req1_data = '0; req1_amt = '0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        chk("rst_out_id", {31'd0, out_id}, 32'd0);
        chk("rst_sh_in", {28'd0, sh_in}, 32'd0);
        chk("rst_sh_s", {30'd0, sh_s}, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;

        // Single request, then a back-to-back second request from the same requester
        rst = 1'b0;
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 4'b1011; req0_amt = 2'd2;
        wait_grant(1'b0, 1'b1, w);
        chk("first_accept_after_reset", w, 32'd0);
        g1 = last_grant_cyc;
        req0_data = 4'b0110; req0_amt = 2'd1;
        @(negedge clk);
        chk("busy_no_ready0", {31'd0, req0_ready}, 32'd0);
        chk("busy_sh_in", {28'd0, sh_in}, 32'd11);
        chk("busy_sh_s", {30'd0, sh_s}, 32'd2);
        wait_result();
        chk("done_no_ready0", {31'd0, req0_ready}, 32'd0);
        wait_grant(1'b0, 1'b1, w);
        chk("accept_spacing", last_grant_cyc - g1, 32'd3);
        req0_valid = 1'b0;
        wait_result();
        @(posedge clk);
        #1;

        // Simultaneous requests held from reset, then round-robin restore
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 4'b1011; req0_amt = 2'd1;
        req1_valid = 1'b1; req1_data = 4'b1111; req1_amt = 2'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_grant(1'b0, 1'b1, w);
        wait_result();
        wait_grant(1'b1, 1'b1, w);
        wait_result();
        wait_grant(1'b0, 1'b1, w);

        // Backpressure: result held, req1 kept waiting
        out_ready = 1'b0;
        wait_result();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", {28'd0, out_data}, 32'd5);
            chk("bp_out_id", {31'd0, out_id}, 32'd0);
            chk("bp_no_ready1", {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        wait_grant(1'b1, 1'b1, w);
        chk("bp_grant_after_idle", w, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_result();
        @(posedge clk);
        #1;

        // Boundary shift amounts
        serve(1'b0, 4'b1010, 2'd0);
        serve(1'b1, 4'b1000, 2'd3);
        serve(1'b0, 4'b0111, 2'd3);

        // Reset while DONE with out_valid high
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 4'b0101; req0_amt = 2'd1;
        wait_grant(1'b0, 1'b1, w);
        req0_valid = 1'b0;
        wait_result();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {28'd0, out_data}, 32'd0);
        chk("arst_out_id", {31'd0, out_id}, 32'd0);
        chk("arst_sh_in", {28'd0, sh_in}, 32'd0);
        chk("arst_sh_s", {30'd0, sh_s}, 32'd0);
        chk("arst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("arst_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        // ptr was 1 before reset; a tie must now go to requester 0
        req0_valid = 1'b1; req0_data = 4'b1100; req0_amt = 2'd2;
        req1_valid = 1'b1; req1_data = 4'b0011; req1_amt = 2'd1;
        rst = 1'b0;
        out_ready = 1'b1;
        wait_grant(1'b0, 1'b1, w);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_result();
        @(posedge clk);
        #1;

        // Reset mid-BUSY: the in-flight request never produces a result
        req1_valid = 1'b1; req1_data = 4'b0110; req1_amt = 2'd1;
        wait_grant(1'b1, 1'b0, w);
        req1_valid = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("busy_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        serve(1'b1, 4'b1110, 2'd1);

        chk("sb_drained", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin scheduler that shares one combinational logical-right barrel shifter between two requesters. Each request is a data word and a shift amount. The block accepts one request at a time and drives the shared shifter from registered operands. It captures the shifter output and presents it with the requester ID on a valid/ready result port. It sits between the client logic and the single shifter instance, which is instantiated alongside it at the top level.

## Interface
- N, default 4: data width; power of two, ≥ 2.
- S, default $clog2(N): shift-amount width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req0_valid  in  1  requester 0 has a request.
- req0_data  in  N  requester 0 operand.
- req0_amt  in  S  requester 0 shift amount.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid, req1_data, req1_amt, req1_ready: same as requester 0, for requester 1.
- sh_in  out  N  operand to shared shifter.
- sh_s  out  S  shift amount to shared shifter.
- sh_result  in  N  shifter output; combinational from sh_in/sh_s; logical right shift with zero fill.
- out_valid  out  1  result available.
- out_data  out  N  shifted result.
- out_id  out  1  requester that issued the result.
- out_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Round-robin pointer `ptr` (1 bit) names the requester with priority.
- **IDLE arbitration:**
  - Only one valid: that requester is granted.
  - Both valid: requester `ptr` is granted.
  - reqX_ready = (state==IDLE) & granted==X; combinational from state, ptr and valids.
  - At most one ready is high in any cycle.
  - ready is never high outside IDLE.
- **Acceptance** (valid & ready on a rising edge):
  - sh_in ← data, sh_s ← amt, id register ← X.
  - → BUSY.
- **BUSY:** sh_in/sh_s stay stable. At the edge ending BUSY:
  - out_data ← sh_result, out_id ← id register, out_valid ← 1.
  - → DONE.
- **DONE:** out_valid, out_data and out_id stay stable until out_ready=1 at an edge. On that edge:
  - out_valid ← 0.
  - ptr ← ~out_id; the requester just served loses priority.
  - → IDLE.
- sh_in/sh_s keep their last values outside BUSY; they are not cleared.
- Requests not granted are not dropped; requester holds valid/data/amt until ready.
- Requester data/amt changes while not granted are legal; the value sampled at the accepting edge is used.
- No shift-amount saturation is needed: S bits cover 0..N-1 exactly.
- amt=0 passes data unchanged.
- **Reset (any time, including mid-BUSY/DONE):**
  - state=IDLE, ptr=0, out_valid=0, out_data=0, out_id=0, sh_in=0, sh_s=0.
  - Any in-flight request is discarded; the requester is not re-notified.

## Timing
- Edge T accepts request → BUSY during cycle T..T+1.
- out_valid rises after edge T+1.
- Minimum latency: 2 cycles from acceptance to out_valid.
- Result accepted at edge T+2 (out_ready already high) → IDLE in cycle after T+2. Next acceptance earliest at edge T+3.
- Peak throughput: 1 request per 3 cycles.
- With out_ready held low, DONE persists indefinitely. No requests are accepted while in DONE.
- Combinational paths:
  - req*_valid → req*_ready.
  - sh_in/sh_s → sh_result (external).
- No combinational path from out_ready to any output.
- rst deassertion: first acceptance possible at the first rising edge with rst low.

## Test plan
- **Reset check:** assert rst mid-DONE with out_valid=1 → all outputs zero immediately (async), state IDLE, ptr=0, req0_ready/req1_ready=0 while no valids.
- **Single request, N=4:** req0 data=4'b1011, amt=2, out_ready=1 → req0_ready high one cycle; out_valid 2 cycles later with out_data=4'b0010, out_id=0; next accept ≥3 cycles after the first.
- **Simultaneous requests:** req0 (1011, amt 1) and req1 (1111, amt 3) held valid from reset → results in order 0101/id0, then 0001/id1.
- **Round-robin restore:** with both still valid after the above, the next grant goes to req0.
- **Backpressure:** out_ready=0 for 10 cycles after out_valid → out_valid/out_data/out_id stable. req1_valid high throughout, but req1_ready stays 0. Raising out_ready → handshake completes; req1 is accepted the cycle after returning to IDLE.
- **Boundary amounts:** amt=0 on 1010 → 1010. amt=N-1 on 1000 → 0001. amt=3 on 0111 → 0000.
- **Reset mid-BUSY:** assert rst in the cycle after acceptance → no out_valid is ever produced for that request. After release, a fresh req1 request is served normally with out_id=1.
